// File: rtl/uart_tx_fifo_if.sv
// Host/serializer-facing signal bundle for the UART transmit FIFO.
// The master modport is the side that writes, reads and configures the FIFO.
interface uart_tx_fifo_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clear;
  logic             push;
  logic [WIDTH-1:0] din;
  logic             pop;
  logic [3:0]       threshold;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [4:0]       count;
  logic             overrun;
  logic             low_water;

  modport master (
    output clear, push, din, pop, threshold,
    input  dout, empty, full, count, overrun, low_water
  );

  modport slave (
    input  clear, push, din, pop, threshold,
    output dout, empty, full, count, overrun, low_water
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 16-entry first-word-fall-through transmit FIFO feeding the UART serializer.
// Drops writes when full (sticky overrun) and ignores reads when empty.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             empty, full;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A push into a full FIFO is only accepted if the head leaves the same cycle.
  assign push_ok = bus.push && !rst && !bus.clear && (!full || bus.pop);
  assign pop_ok  = bus.pop && !rst && !bus.clear && !empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (bus.clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.push && full && !bus.pop) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= bus.din;
  end

  assign bus.dout      = empty ? '0 : mem[rd_ptr_q];
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.overrun   = overrun_q;
  assign bus.low_water = (count_q <= {1'b0, bus.threshold});
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: reset, FWFT data path,
// full/empty corner cases, low-water, clear, pointer wrap and async reset.
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  uart_tx_fifo_if #(.WIDTH(8)) u_bus ();

  uart_tx_fifo #(.DEPTH(16), .WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the edge.
  task automatic cycle(input logic p, input logic [7:0] d, input logic r, input logic c);
    u_bus.push  = p;
    u_bus.din   = d;
    u_bus.pop   = r;
    u_bus.clear = c;
    @(posedge clk);
    #1;
    u_bus.push  = 1'b0;
    u_bus.pop   = 1'b0;
    u_bus.clear = 1'b0;
    u_bus.din   = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] v;

    u_bus.push = 1'b0; u_bus.pop = 1'b0; u_bus.clear = 1'b0;
    u_bus.din = 8'h00; u_bus.threshold = 4'd4;

    #3;
    check("rst_empty", u_bus.empty, 1);
    check("rst_full", u_bus.full, 0);
    check("rst_low_water", u_bus.low_water, 1);
    check("rst_dout", u_bus.dout, 8'h00);
    check("rst_count", u_bus.count, 0);
    check("rst_overrun", u_bus.overrun, 0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Single push / pop and pop-while-empty
    cycle(1, 8'hA5, 0, 0);
    check("a5_count", u_bus.count, 1);
    check("a5_empty", u_bus.empty, 0);
    check("a5_dout", u_bus.dout, 8'hA5);
    cycle(0, 8'h00, 1, 0);
    check("pop_count", u_bus.count, 0);
    check("pop_empty", u_bus.empty, 1);
    check("pop_dout", u_bus.dout, 8'h00);
    cycle(0, 8'h00, 1, 0);
    check("underflow_count", u_bus.count, 0);

    // Fill, overflow drop, ordered drain
    for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0);
    check("fill_full", u_bus.full, 1);
    check("fill_count", u_bus.count, 16);
    check("fill_overrun", u_bus.overrun, 0);
    cycle(1, 8'hFF, 0, 0);
    check("ovf_count", u_bus.count, 16);
    check("ovf_overrun", u_bus.overrun, 1);
    for (int i = 0; i < 16; i++) begin
      check("drain_order", u_bus.dout, 8'(i));
      cycle(0, 8'h00, 1, 0);
    end
    check("drain_empty", u_bus.empty, 1);
    check("drain_dout", u_bus.dout, 8'h00);
    check("overrun_sticky", u_bus.overrun, 1);
    cycle(0, 8'h00, 0, 1);
    check("clr_overrun", u_bus.overrun, 0);

    // Push+pop while full
    for (int i = 0; i < 16; i++) cycle(1, 8'(8'h10 + i), 0, 0);
    cycle(1, 8'h55, 1, 0);
    check("fullpp_count", u_bus.count, 16);
    check("fullpp_overrun", u_bus.overrun, 0);
    for (int i = 1; i < 16; i++) begin
      check("fullpp_order", u_bus.dout, 8'(8'h10 + i));
      cycle(0, 8'h00, 1, 0);
    end
    check("fullpp_last", u_bus.dout, 8'h55);
    cycle(0, 8'h00, 1, 0);
    check("fullpp_empty", u_bus.empty, 1);

    // Push+pop while empty
    cycle(1, 8'h3C, 1, 0);
    check("emptypp_count", u_bus.count, 1);
    check("emptypp_dout", u_bus.dout, 8'h3C);
    cycle(0, 8'h00, 1, 0);

    // Low-water at threshold 4, then clear beats push
    check("lw_0", u_bus.low_water, 1);
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 8'(8'h40 + i), 0, 0);
      if (i <= 5) check($sformatf("lw_%0d", i), u_bus.low_water, (i <= 4) ? 1 : 0);
    end
    cycle(1, 8'hEE, 0, 0);
    check("lw_overrun", u_bus.overrun, 1);
    cycle(1, 8'h77, 0, 1);
    check("clr_count", u_bus.count, 0);
    check("clr_overrun2", u_bus.overrun, 0);
    check("clr_empty", u_bus.empty, 1);
    check("clr_dout", u_bus.dout, 8'h00);
    cycle(1, 8'h09, 0, 0);
    check("post_clr_dout", u_bus.dout, 8'h09);

    // Interleaved traffic wrapping both pointers
    q.push_back(8'h09);
    for (int i = 0; i < 20; i++) begin
      v = 8'(i * 7 + 3);
      if (i[0]) begin
        check("wrap_order", u_bus.dout, q[0]);
        void'(q.pop_front());
      end
      q.push_back(v);
      cycle(1, v, i[0], 0);
    end
    check("wrap_count", u_bus.count, 11);
    while (q.size() > 0) begin
      check("wrap_drain", u_bus.dout, q[0]);
      void'(q.pop_front());
      cycle(0, 8'h00, 1, 0);
    end
    check("wrap_empty", u_bus.empty, 1);

    // Asynchronous reset mid-operation
    cycle(1, 8'hE1, 0, 0);
    cycle(1, 8'hE2, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_empty", u_bus.empty, 1);
    check("arst_count", u_bus.count, 0);
    check("arst_dout", u_bus.dout, 8'h00);
    check("arst_low_water", u_bus.low_water, 1);
    cycle(1, 8'hEE, 0, 0);
    check("arst_push_ignored", u_bus.count, 0);
    #2 rst = 1'b0;
    cycle(1, 8'hC3, 0, 0);
    check("arst_first_count", u_bus.count, 1);
    check("arst_first_dout", u_bus.dout, 8'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have a parameter DEPTH, default 16, giving the number of entries; only 16 is supported.
REQ-002 The block SHALL have a parameter WIDTH, default 8, giving the data bits per entry.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous reset, active-high.
REQ-005 Port clear, input, 1 bit: synchronous FIFO flush.
REQ-006 Port push, input, 1 bit: host write strobe; one push per cycle high.
REQ-007 Port din, input, 8 bits: host write data, sampled when push=1.
REQ-008 Port pop, input, 1 bit: read strobe from the TX serializer; one pop per cycle high.
REQ-009 Port threshold, input, 4 bits: low-water level.
REQ-010 Port dout, output, 8 bits: head entry, first-word fall-through.
REQ-011 Port empty, output, 1 bit: FIFO holds no entries; drives the serializer's thre input.
REQ-012 Port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-013 Port count, output, 5 bits: occupancy, range 0..16.
REQ-014 Port overrun, output, 1 bit: sticky flag, a push was dropped.
REQ-015 Port low_water, output, 1 bit: occupancy is at or below threshold.

Function
REQ-016 Storage SHALL be 16x8, with 4-bit write pointer wr_ptr and 4-bit read pointer rd_ptr, wrapping from 15 to 0.
REQ-017 The storage array SHALL NOT be reset; pointers, count and flags SHALL be reset.
REQ-018 dout SHALL equal mem[rd_ptr] combinationally while empty=0, and 8'h00 while empty=1; the serializer samples dout in the same cycle it sees empty=0.
REQ-019 Accepted push: mem[wr_ptr] <= din, wr_ptr increments, count increments; a push is accepted when full=0, or when full=1 and pop=1 in the same cycle.
REQ-020 Accepted pop: rd_ptr increments, count decrements; a pop is accepted when empty=0.
REQ-021 pop while empty=1 SHALL be ignored with no state change; no underflow flag exists.
REQ-022 Simultaneous push and pop with 0<count<16: both accepted, count unchanged.
REQ-023 Simultaneous push and pop with count=0: push accepted, pop ignored, count becomes 1.
REQ-024 Simultaneous push and pop with count=16: both accepted, count stays 16, overrun unchanged.
REQ-025 push with full=1 and pop=0: data dropped, pointers unchanged, overrun <= 1 next cycle.
REQ-026 overrun SHALL stay high until clear or rst.
REQ-027 clear=1 SHALL set wr_ptr=0, rd_ptr=0, count=0 and overrun=0 next cycle, and SHALL override push and pop in the same cycle.
REQ-028 empty SHALL be (count==0), full SHALL be (count==16), and low_water SHALL be (count <= threshold), all decoded from the registered count with no extra latency.
REQ-029 Flag latency: a push in cycle N SHALL be visible on count, empty and dout in cycle N+1.
REQ-030 The pop strobe is a registered 1-cycle pulse from the consumer; the block SHALL treat each high cycle as exactly one read and SHALL NOT edge-detect it.

Reset
REQ-031 On rst=1, at once and regardless of clk: wr_ptr=0, rd_ptr=0, count=0, overrun=0.
REQ-032 During reset the outputs SHALL be empty=1, full=0, low_water=1, dout=8'h00.
REQ-033 rst asserted mid-operation SHALL discard all entries; on release the first push SHALL land at address 0.
REQ-034 push and pop SHALL be ignored while rst=1.

Verification
REQ-035 Reset then push 8'hA5 in one cycle: next cycle count=1, empty=0, dout=8'hA5; pop one cycle: next cycle count=0, empty=1, dout=8'h00.
REQ-036 Push 16 values 8'h00..8'h0F, then push 8'hFF: full=1, count=16, overrun=1; 16 pops return 8'h00..8'h0F in order, and 8'hFF is never output.
REQ-037 Fill to 16, then one cycle with push=1 (8'h55) and pop=1: count stays 16, overrun stays 0; the last read of a full drain returns 8'h55.
REQ-038 count=0, push=1 (8'h3C) and pop=1 together: count=1, dout=8'h3C.
REQ-039 threshold=4: low_water=1 for count 0..4 and 0 for count 5; set overrun, then pulse clear with push=1: count=0, overrun=0, entry not written.
REQ-040 Push 20 items with interleaved pops so that pointers wrap past 15: output order matches input order; then assert rst asynchronously between clock edges: empty=1 at once.
